x_sweep_ctrl: RTL and testbench
===============================

# x_sweep_ctrl

Upstream sequencer for the X-coordinate counter. On a start request it latches a sweep window (start, end, step mode, line count) and drives the counter's enable, step-mode and load-value inputs cycle by cycle, feeding the counter output back as the next load value. It flags each valid X coordinate to the downstream pattern logic, tracks the line index and signals completion. The block adds no arithmetic of its own to the X path; the counter performs the add.

## Interface
Parameters: none (widths fixed: X 12 bits, lines 10 bits).
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  sweep request, sampled only in IDLE
- hold  in  1  pause; freezes the sweep while in RUN
- step_mode  in  2  step code latched at start: 00→promoted to 01, 01=+1, 10=+4, 11=+8
- x_start  in  12  first X of each line, latched at start
- x_end  in  12  inclusive X limit, latched at start
- num_lines  in  10  lines per sweep, latched at start; 0 treated as 1
- cnt_out  in  12  counter output (fed back)
- cnt_enb  out  1  counter enable
- Xmode  out  2  counter step mode
- LoadVal  out  12  counter load value
- x_valid  out  1  cnt_out is a valid coordinate this cycle
- line_idx  out  10  current line, 0-based
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse

## Operation
- FSM states: IDLE, LOAD, RUN, DONE. State, latched parameters and line_idx are registered; outputs are combinational from state, latched parameters, hold and cnt_out.
- IDLE: cnt_enb=0, Xmode=00, LoadVal=0, x_valid=0. On start=1, latch inputs, clear line_idx, go to LOAD.
- LOAD: cnt_enb=1, Xmode=00, LoadVal=x_start_r. The counter then presents x_start on the next cycle. Go to RUN.
- RUN, hold=1: cnt_enb=1, Xmode=00, LoadVal=cnt_out (the counter holds its value), x_valid=0, stay in RUN.
- RUN, hold=0: x_valid=1. Compute the last-pixel condition as 13-bit {0,cnt_out}+delta > {0,x_end_r}.
  - Not last: LoadVal=cnt_out, Xmode=mode_r, stay in RUN.
  - Last, and line_idx==lines_r−1: go to DONE.
  - Last, otherwise: line_idx+1, go to LOAD. Counter inputs this cycle are cnt_enb=1, Xmode=00, LoadVal=x_start_r.
- DONE: cnt_enb=0, done=1, x_valid=0, go to IDLE. line_idx keeps its final value until the next start.

## Timing
- Reset values: state=IDLE; cnt_enb=0, Xmode=00, LoadVal=0, x_valid=0, line_idx=0, busy=0, done=0.
- Counter latency is 1 cycle. LOAD is a single bubble cycle per line.
- Cycles per line = 1 + number of pixels. The sweep ends with one DONE cycle.
- start is ignored while busy. Input changes after latching have no effect.
- x_start > x_end: exactly one pixel per line, at x_start.
- Wrap-around: the 13-bit compare guarantees X never wraps past 4095. Example: x_start=4092, x_end=4095, +4 gives one pixel.
- hold at the last pixel: no advance; the last-pixel decision is taken on the first cycle with hold=0.
- hold outside RUN has no effect.
- Reset asserted mid-sweep: immediate return to reset values. No done pulse.

## Test plan
- Reset mid-RUN → all outputs return to reset values in the same cycle they are asserted, with no done. A fresh start afterwards behaves as in the first scenario.
- Basic sweep: x_start=0, x_end=7, mode 01, 1 line, start at cycle 0 → LOAD at cycle 1, x_valid with cnt_out 0..7 on cycles 2–9, done on cycle 10, busy low on cycle 11.
- Step and boundary: x_start=3, x_end=20, mode 10, 2 lines → X sequence 3, 7, 11, 15, 19 per line. line_idx goes 0→1. Exactly one LOAD bubble between lines. 13 cycles from LOAD to DONE.
- Hold: hold=1 for 3 cycles while cnt_out=5 (mode 01) → cnt_out stays 5 and x_valid=0 for 3 cycles, then resumes at 6. Total sweep length grows by 3.
- Edge windows:
  - x_start=4090, x_end=4095, mode 11 → single pixel 4090, no wrap.
  - x_start=10, x_end=2 → single pixel 10.
  - num_lines=0 → 1 line.
  - step_mode=00 → steps of +1.
- Start while busy: pulse start in RUN with different x_start → ignored, sweep unchanged. A start in the cycle after DONE is accepted.

Source files
------------

// File: rtl/x_sweep_ctrl.sv
// X sweep sequencer: walks an external counter across [x_start, x_end] for num_lines lines.
// Latency: counter outputs are combinational; cnt_out reaches x_start two cycles after start is seen.
// Backpressure: hold freezes the sweep in RUN (counter reloads its own value, no valid pixel).
module x_sweep_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        hold,
    input  logic [1:0]  step_mode,
    input  logic [11:0] x_start,
    input  logic [11:0] x_end,
    input  logic [9:0]  num_lines,
    input  logic [11:0] cnt_out,
    output logic        cnt_enb,
    output logic [1:0]  Xmode,
    output logic [11:0] LoadVal,
    output logic        x_valid,
    output logic [9:0]  line_idx,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

    state_t      state, state_nxt;
    logic [1:0]  mode_r;
    logic [11:0] x_start_r;
    logic [11:0] x_end_r;
    logic [9:0]  lines_r;
    logic [12:0] delta;
    logic        is_last;
    logic        last_line;
    logic        latch;
    logic        line_inc;

    always_comb begin
        case (mode_r)
            2'b10:   delta = 13'd4;
            2'b11:   delta = 13'd8;
            default: delta = 13'd1;
        endcase
    end

    // One extra bit so an add that would pass 4095 still compares as beyond x_end.
    assign is_last   = ({1'b0, cnt_out} + delta) > {1'b0, x_end_r};
    assign last_line = (line_idx == (lines_r - 10'd1));
    assign busy      = (state != S_IDLE);

    always_comb begin
        state_nxt = state;
        cnt_enb   = 1'b0;
        Xmode     = 2'b00;
        LoadVal   = 12'd0;
        x_valid   = 1'b0;
        done      = 1'b0;
        latch     = 1'b0;
        line_inc  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    latch     = 1'b1;
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                cnt_enb   = 1'b1;
                LoadVal   = x_start_r;
                state_nxt = S_RUN;
            end
            S_RUN: begin
                if (hold) begin
                    cnt_enb = 1'b1;
                    LoadVal = cnt_out;
                end else begin
                    x_valid = 1'b1;
                    if (!is_last) begin
                        cnt_enb = 1'b1;
                        Xmode   = mode_r;
                        LoadVal = cnt_out;
                    end else if (last_line) begin
                        state_nxt = S_DONE;
                    end else begin
                        line_inc  = 1'b1;
                        cnt_enb   = 1'b1;
                        LoadVal   = x_start_r;
                        state_nxt = S_LOAD;
                    end
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            mode_r    <= 2'b01;
            x_start_r <= 12'd0;
            x_end_r   <= 12'd0;
            lines_r   <= 10'd1;
            line_idx  <= 10'd0;
        end else begin
            state <= state_nxt;
            if (latch) begin
                mode_r    <= (step_mode == 2'b00) ? 2'b01 : step_mode;
                x_start_r <= x_start;
                x_end_r   <= x_end;
                lines_r   <= (num_lines == 10'd0) ? 10'd1 : num_lines;
                line_idx  <= 10'd0;
            end else if (line_inc) begin
                line_idx <= line_idx + 10'd1;
            end
        end
    end

endmodule

// File: tb/tb_x_sweep_ctrl.sv
// Bench for x_sweep_ctrl with a behavioural X counter closing the feedback loop.
module tb_x_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        hold;
    logic [1:0]  step_mode;
    logic [11:0] x_start;
    logic [11:0] x_end;
    logic [9:0]  num_lines;
    logic [11:0] cnt_out;
    logic        cnt_enb;
    logic [1:0]  Xmode;
    logic [11:0] LoadVal;
    logic        x_valid;
    logic [9:0]  line_idx;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int line;
        int x;
    } exp_t;

    typedef struct {
        logic [11:0] xs;
        logic [11:0] xe;
        logic [1:0]  md;
        logic [9:0]  nl;
        int          exp_cyc;   // cycles from LOAD through DONE inclusive
        int          hold_x;    // X at which to hold for 3 cycles, -1 = none
        bit          poke;      // pulse start mid-sweep
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[9];

    x_sweep_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .hold      (hold),
        .step_mode (step_mode),
        .x_start   (x_start),
        .x_end     (x_end),
        .num_lines (num_lines),
        .cnt_out   (cnt_out),
        .cnt_enb   (cnt_enb),
        .Xmode     (Xmode),
        .LoadVal   (LoadVal),
        .x_valid   (x_valid),
        .line_idx  (line_idx),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Counter: 1-cycle latency, loads LoadVal plus the step selected by Xmode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_out <= 12'd0;
        else if (cnt_enb)
            case (Xmode)
                2'b01:   cnt_out <= LoadVal + 12'd1;
                2'b10:   cnt_out <= LoadVal + 12'd4;
                2'b11:   cnt_out <= LoadVal + 12'd8;
                default: cnt_out <= LoadVal;
            endcase
    end

    always @(negedge clk) begin
        if (rst_n && x_valid) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL pixel_unexpected actual x=%0d line=%0d required none", cnt_out, line_idx);
            end else begin
                mon_e = sb.pop_front();
                if (int'(cnt_out) != mon_e.x || int'(line_idx) != mon_e.line) begin
                    bad++;
                    $display("FAIL pixel actual x=%0d line=%0d required x=%0d line=%0d",
                             cnt_out, line_idx, mon_e.x, mon_e.line);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic int step_of(input logic [1:0] md);
        case (md)
            2'b10:   return 4;
            2'b11:   return 8;
            default: return 1;
        endcase
    endfunction

    task automatic push_expected(input vec_t v);
        int lines;
        int x;
        lines = (v.nl == 0) ? 1 : int'(v.nl);
        for (int l = 0; l < lines; l++) begin
            x = int'(v.xs);
            do begin
                sb.push_back('{line: l, x: x});
                x += step_of(v.md);
            end while (x <= int'(v.xe));
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_cnt_enb"}, int'(cnt_enb), 0);
        check({tag, "_xmode"}, int'(Xmode), 0);
        check({tag, "_loadval"}, int'(LoadVal), 0);
        check({tag, "_x_valid"}, int'(x_valid), 0);
        check({tag, "_line_idx"}, int'(line_idx), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
    endtask

    // Called at posedge+1 while IDLE; returns at posedge+1 of the cycle after DONE.
    task automatic run_sweep(input vec_t v, input int idx);
        int  n;
        bit  held;
        push_expected(v);
        x_start   = v.xs;
        x_end     = v.xe;
        step_mode = v.md;
        num_lines = v.nl;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        x_start   = ~v.xs;
        x_end     = 12'd0;
        step_mode = ~v.md;
        num_lines = 10'd7;
        check($sformatf("v%0d_busy_load", idx), int'(busy), 1);
        n    = 1;
        held = 1'b0;
        while (!done && n < 300) begin
            if (v.hold_x >= 0 && !held && x_valid && int'(cnt_out) == v.hold_x) begin
                held = 1'b1;
                hold = 1'b1;
                for (int i = 0; i < 3; i++) begin
                    #1;
                    check($sformatf("v%0d_hold_valid", idx), int'(x_valid), 0);
                    check($sformatf("v%0d_hold_x", idx), int'(cnt_out), v.hold_x);
                    @(posedge clk); #1;
                    n++;
                end
                hold = 1'b0;
            end else begin
                if (v.poke && n == 4) begin
                    start   = 1'b1;
                    x_start = 12'd777;
                end else begin
                    start = 1'b0;
                end
                @(posedge clk); #1;
                n++;
            end
        end
        start = 1'b0;
        check($sformatf("v%0d_done_seen", idx), int'(done), 1);
        check($sformatf("v%0d_cycles", idx), n, v.exp_cyc);
        check($sformatf("v%0d_final_line", idx), int'(line_idx), ((v.nl == 0) ? 1 : int'(v.nl)) - 1);
        check($sformatf("v%0d_sb_left", idx), sb.size(), 0);
        sb.delete();
        @(posedge clk); #1;
        check($sformatf("v%0d_busy_after", idx), int'(busy), 0);
        check($sformatf("v%0d_done_after", idx), int'(done), 0);
    endtask

    initial begin
        vec_t rv;
        vecs[0] = '{xs: 12'd0,    xe: 12'd7,    md: 2'b01, nl: 10'd1, exp_cyc: 10, hold_x: -1, poke: 1'b0};
        vecs[1] = '{xs: 12'd3,    xe: 12'd20,   md: 2'b10, nl: 10'd2, exp_cyc: 13, hold_x: -1, poke: 1'b0};
        vecs[2] = '{xs: 12'd0,    xe: 12'd9,    md: 2'b01, nl: 10'd1, exp_cyc: 15, hold_x: 5,  poke: 1'b0};
        vecs[3] = '{xs: 12'd4090, xe: 12'd4095, md: 2'b11, nl: 10'd1, exp_cyc: 3,  hold_x: -1, poke: 1'b0};
        vecs[4] = '{xs: 12'd10,   xe: 12'd2,    md: 2'b01, nl: 10'd1, exp_cyc: 3,  hold_x: -1, poke: 1'b0};
        vecs[5] = '{xs: 12'd0,    xe: 12'd3,    md: 2'b01, nl: 10'd0, exp_cyc: 6,  hold_x: -1, poke: 1'b0};
        vecs[6] = '{xs: 12'd0,    xe: 12'd5,    md: 2'b00, nl: 10'd1, exp_cyc: 8,  hold_x: -1, poke: 1'b0};
        vecs[7] = '{xs: 12'd4092, xe: 12'd4095, md: 2'b10, nl: 10'd3, exp_cyc: 7,  hold_x: -1, poke: 1'b0};
        vecs[8] = '{xs: 12'd3,    xe: 12'd20,   md: 2'b10, nl: 10'd2, exp_cyc: 13, hold_x: -1, poke: 1'b1};

        rst_n     = 1'b0;
        start     = 1'b0;
        hold      = 1'b1;
        step_mode = 2'b00;
        x_start   = 12'd0;
        x_end     = 12'd0;
        num_lines = 10'd0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("por");
        rst_n = 1'b1;
        hold  = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++)
            run_sweep(vecs[i], i);

        // Reset asserted during line 1 of a 3-line sweep.
        rv = '{xs: 12'd0, xe: 12'd1, md: 2'b01, nl: 10'd3, exp_cyc: 0, hold_x: -1, poke: 1'b0};
        push_expected(rv);
        x_start   = rv.xs;
        x_end     = rv.xe;
        step_mode = rv.md;
        num_lines = rv.nl;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        check("pre_rst_line", int'(line_idx), 1);
        check("pre_rst_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check_reset_vals("mid_rst");
        sb.delete();
        @(posedge clk); #1;
        check("rst_no_done", int'(done), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_sweep(vecs[0], 9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        bad++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
